// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the MIPS pipeline stage registers.
package mips_pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 32;
  localparam logic [PIPE_WIDTH-1:0] PIPE_RESET_VAL = 32'h0000_0000;

  typedef logic [PIPE_WIDTH-1:0] pipe_word_t;

endpackage : mips_pipe_pkg

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus through one pipeline stage: upstream side, downstream side
// and the complemented data output.
interface pipe_stage_reg_if
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_data_n;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_data_n
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_data_n
  );

endinterface : pipe_stage_reg_if

// File: rtl/pipe_reg_slot.sv
// One storage slot of a pipeline stage: WIDTH-bit data register plus valid bit.
// Priority is reset, then clear, then load; clear and reset both reload RESET_VAL.
module pipe_reg_slot
  import mips_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Next-state selection for the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : pipe_reg_slot

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and complemented output.
// Define PIPE_STAGE_REG_SKID_EN to add a skid slot that registers in_ready.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_reg_if.slave bus
);

  logic             main_v_s;
  logic [WIDTH-1:0] main_data_s;
  logic [WIDTH-1:0] main_din_s;
  logic             main_load_s;
  logic             main_clear_s;
  logic             xfer_in_s;
  logic             xfer_out_s;

  assign xfer_in_s  = bus.in_valid && bus.in_ready;
  assign xfer_out_s = main_v_s && bus.out_ready;

  pipe_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (main_load_s),
    .clear_i (main_clear_s),
    .data_i  (main_din_s),
    .valid_o (main_v_s),
    .data_o  (main_data_s)
  );

`ifdef PIPE_STAGE_REG_SKID_EN
  logic             skid_v_s;
  logic [WIDTH-1:0] skid_data_s;
  logic             skid_load_s;
  logic             skid_clear_s;

  pipe_reg_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (skid_load_s),
    .clear_i (skid_clear_s),
    .data_i  (bus.in_data),
    .valid_o (skid_v_s),
    .data_o  (skid_data_s)
  );

  // Skid is only ever full while main is full, so a free skid means room.
  assign bus.in_ready = !skid_v_s;

  // Steering between upstream, skid and main slot; the skid word always drains first.
  always_comb begin
    main_load_s  = 1'b0;
    main_clear_s = 1'b0;
    main_din_s   = bus.in_data;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (flush) begin
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else if (xfer_out_s && skid_v_s) begin
      main_load_s  = 1'b1;
      main_din_s   = skid_data_s;
      skid_clear_s = 1'b1;
    end else if (xfer_in_s && (!main_v_s || xfer_out_s)) begin
      main_load_s = 1'b1;
    end else if (xfer_in_s) begin
      skid_load_s = 1'b1;
    end else if (xfer_out_s) begin
      main_clear_s = 1'b1;
    end else begin
      main_load_s = 1'b0;
    end
  end
`else
  assign bus.in_ready = !main_v_s || bus.out_ready;

  // Single-slot steering: load on accept, empty on drain, flush wins.
  always_comb begin
    main_load_s  = 1'b0;
    main_clear_s = 1'b0;
    main_din_s   = bus.in_data;
    if (flush) begin
      main_clear_s = 1'b1;
    end else if (xfer_in_s) begin
      main_load_s = 1'b1;
    end else if (xfer_out_s) begin
      main_clear_s = 1'b1;
    end else begin
      main_load_s = 1'b0;
    end
  end
`endif

  assign bus.out_valid  = main_v_s;
  assign bus.out_data   = main_data_s;
  assign bus.out_data_n = ~main_data_s;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg at WIDTH 32, 1 and 128; expected words go into
// per-instance queues and a negedge monitor checks every transfer out.
module tb_pipe_stage_reg;
  import mips_pipe_pkg::*;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [127:0] q32[$];
  logic [127:0] q1[$];
  logic [127:0] q128[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(32))  b32();
  pipe_stage_reg_if #(.WIDTH(1))   b1();
  pipe_stage_reg_if #(.WIDTH(128)) b128();

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0000_0000)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32));
  pipe_stage_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b1));
  pipe_stage_reg #(.WIDTH(128), .RESET_VAL({128{1'b1}})) u_d128 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b128));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every transfer out must match the oldest expected word.
  always @(negedge clk) begin
    logic [127:0] e;
    if (b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        chk("mon32_unexpected", 128'(b32.out_data), 128'hx);
      end else begin
        e = q32.pop_front();
        chk("mon32_data", 128'(b32.out_data), e);
        chk("mon32_n", 128'(b32.out_data_n), {96'h0, ~e[31:0]});
      end
    end
    if (b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        chk("mon1_unexpected", 128'(b1.out_data), 128'hx);
      end else begin
        e = q1.pop_front();
        chkb("mon1_data", b1.out_data, e[0]);
        chkb("mon1_n", b1.out_data_n, ~e[0]);
      end
    end
    if (b128.out_valid && b128.out_ready) begin
      if (q128.size() == 0) begin
        chk("mon128_unexpected", b128.out_data, 128'hx);
      end else begin
        e = q128.pop_front();
        chk("mon128_data", b128.out_data, e);
        chk("mon128_n", b128.out_data_n, ~e);
      end
    end
  end

  initial begin
    logic [127:0] p128 [3];
    logic [2:0]   p1;
    p128[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    p128[1] = 128'h0000_0000_0000_0000_0000_0000_0000_0000;
    p128[2] = 128'h8000_0000_0000_0001_5555_AAAA_FFFF_0000;
    p1      = 3'b010;

    // Reset held two edges with a word offered upstream.
    rst = 1'b1;
    flush = 1'b0;
    b32.in_valid = 1'b1;  b32.in_data = 32'hDEAD_BEEF;  b32.out_ready = 1'b1;
    b1.in_valid = 1'b0;   b1.in_data = 1'b0;            b1.out_ready = 1'b1;
    b128.in_valid = 1'b0; b128.in_data = 128'h0;        b128.out_ready = 1'b1;
    step();
    step();
    chkb("rst_out_valid", b32.out_valid, 1'b0);
    chk("rst_out_data", 128'(b32.out_data), 128'h0);
    chk("rst_out_data_n", 128'(b32.out_data_n), 128'hFFFF_FFFF);
    chkb("rst_in_ready", b32.in_ready, 1'b1);
    chkb("rst1_data", b1.out_data, 1'b1);
    chkb("rst1_data_n", b1.out_data_n, 1'b0);
    chkb("rst1_in_ready", b1.in_ready, 1'b1);
    chk("rst128_data", b128.out_data, {128{1'b1}});
    chk("rst128_data_n", b128.out_data_n, 128'h0);
    rst = 1'b0;
    b32.in_valid = 1'b0;

    // Streaming 1,2,3 back to back.
    for (int i = 1; i <= 3; i++) begin
      b32.in_valid = 1'b1;
      b32.in_data = 32'(i);
      q32.push_back(128'(i));
      step();
      chkb("stream_out_valid", b32.out_valid, 1'b1);
      chk("stream_out_data", 128'(b32.out_data), 128'(i));
      chkb("stream_in_ready", b32.in_ready, 1'b1);
    end
    b32.in_valid = 1'b0;
    step();
    step();
    chkb("stream_drained", b32.out_valid, 1'b0);

    // Stall with 0xA5 held; skid build also takes 0x5A.
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1;
    b32.in_data = 32'h0000_00A5;
    q32.push_back(128'h0000_00A5);
    step();
    b32.in_valid = 1'b0;
    chkb("stall_in_ready", b32.in_ready, SKID);
`ifdef PIPE_STAGE_REG_SKID_EN
    b32.in_valid = 1'b1;
    b32.in_data = 32'h0000_005A;
    q32.push_back(128'h0000_005A);
    step();
    b32.in_valid = 1'b0;
    chkb("skid_full_in_ready", b32.in_ready, 1'b0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chkb("stall_out_valid", b32.out_valid, 1'b1);
      chk("stall_out_data", 128'(b32.out_data), 128'h0000_00A5);
      chk("stall_out_data_n", 128'(b32.out_data_n), 128'hFFFF_FF5A);
    end
    b32.out_ready = 1'b1;
    step();
    step();
    step();
    chkb("stall_drained", b32.out_valid, 1'b0);
    chk("stall_queue_empty", 128'(q32.size()), 128'h0);

    // Flush on the same edge as a transfer in of 0x77.
    b32.in_valid = 1'b1;
    b32.in_data = 32'h0000_0077;
    flush = 1'b1;
    step();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    chkb("flush_out_valid", b32.out_valid, 1'b0);
    chk("flush_out_data", 128'(b32.out_data), 128'h0);
    chk("flush_out_data_n", 128'(b32.out_data_n), 128'hFFFF_FFFF);
    step();
    chkb("flush_still_empty", b32.out_valid, 1'b0);

    // Reset while stalled with every slot full.
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1;
    b32.in_data = 32'h0000_0011;
    q32.push_back(128'h0000_0011);
    step();
`ifdef PIPE_STAGE_REG_SKID_EN
    b32.in_data = 32'h0000_0022;
    q32.push_back(128'h0000_0022);
    step();
`endif
    b32.in_valid = 1'b0;
    chkb("full_in_ready", b32.in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q32.delete();
    chkb("midrst_out_valid", b32.out_valid, 1'b0);
    chkb("midrst_in_ready", b32.in_ready, 1'b1);
    chk("midrst_out_data", 128'(b32.out_data), 128'h0);
    b32.out_ready = 1'b1;
    step();
    step();
    chkb("midrst_no_replay", b32.out_valid, 1'b0);

    // Width sweep: stream three words through the 1-bit and 128-bit stages.
    for (int i = 0; i < 3; i++) begin
      b1.in_valid = 1'b1;
      b1.in_data = p1[i];
      q1.push_back(128'(p1[i]));
      b128.in_valid = 1'b1;
      b128.in_data = p128[i];
      q128.push_back(p128[i]);
      step();
      chkb("w1_out_data", b1.out_data, p1[i]);
      chk("w128_out_data", b128.out_data, p128[i]);
    end
    b1.in_valid = 1'b0;
    b128.in_valid = 1'b0;
    step();
    step();
    chk("q1_empty", 128'(q1.size()), 128'h0);
    chk("q128_empty", 128'(q128.size()), 128'h0);
    chk("q32_empty", 128'(q32.size()), 128'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pipe_stage_reg
